// File: rtl/fp4_mac_pkg.sv
// Shared types and constants for the FP4 MAC control path.
// The sequencer state encoding and the delay-line tag live here.
package fp4_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HOLD   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } seq_tag_t;

    localparam int unsigned MUL_LAT_MAX = 4;
    localparam logic [3:0]  FP4_ZERO    = 4'b0000;

endpackage

// File: rtl/fp4_seq_delay.sv
// {valid,last} tag shift register that tracks operand pairs through the multiplier.
// The last stage is registered, so the strobes derived from it are glitch-free.
module fp4_seq_delay
    import fp4_mac_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  seq_tag_t i_tag,
    output seq_tag_t o_tag
);

    seq_tag_t r_stage [DEPTH];

    // Advance every tag one stage per cycle; reset discards in-flight tags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/fp4_dot_sequencer.sv
// Job-level controller for the FP4 MAC datapath: clears the accumulator, counts
// operand pairs, aligns accumulate/flush strobes to the multiplier, returns the result.
module fp4_dot_sequencer
    import fp4_mac_pkg::*;
#(
    parameter int unsigned LEN_W   = 6,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_job_valid,
    input  logic [LEN_W-1:0] i_job_len,
    output logic             o_job_ready,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    output logic             o_acc_clear,
    output logic             o_acc_valid,
    output logic             o_acc_flush,
    input  logic             i_acc_fp4_valid,
    input  logic [3:0]       i_acc_fp4,
    output logic             o_res_valid,
    output logic [3:0]       o_res_fp4,
    input  logic             i_res_ready,
    output logic             o_busy
);

    localparam int unsigned LAT = (MUL_LAT == 0) ? 1 :
                                  ((MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_job_ready;
    logic             r_op_ready;
    logic             r_acc_clear;
    logic             r_res_valid;
    logic             r_busy;
    logic [3:0]       r_res_fp4;
    logic             w_job_fire;
    logic             w_op_fire;
    logic             w_res_fire;
    logic             w_last;
    seq_tag_t         w_push;
    seq_tag_t         w_tag_out;

    assign w_job_fire = i_job_valid & r_job_ready;
    assign w_op_fire  = i_op_valid & r_op_ready;
    assign w_res_fire = r_res_valid & i_res_ready;
    // Compare against N-1 so that N = 2^LEN_W-1 never needs a wrapped count
    assign w_last     = (r_cnt == (r_len - LEN_W'(1)));

    // Next-state decode and delay-line push for the job sequence
    always_comb begin
        w_next = r_state;
        w_push = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_job_fire) begin
                    if (i_job_len == '0) begin
                        w_next = ST_HOLD;
                    end else begin
                        w_next = ST_CLEAR;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_op_fire) begin
                    w_push.valid = 1'b1;
                    w_push.last  = w_last;
                    if (w_last) begin
                        w_next = ST_DRAIN;
                    end else begin
                        w_next = ST_STREAM;
                    end
                end else begin
                    w_next = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (i_acc_fp4_valid) begin
                    w_next = ST_HOLD;
                end else begin
                    w_next = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (w_res_fire) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register; handshake and strobe outputs are registered from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_job_ready <= 1'b1;
            r_op_ready  <= 1'b0;
            r_acc_clear <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_job_ready <= (w_next == ST_IDLE);
            r_op_ready  <= (w_next == ST_STREAM);
            r_acc_clear <= (w_next == ST_CLEAR);
            r_res_valid <= (w_next == ST_HOLD);
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    // Job length latch and operand issue counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_job_fire) begin
            r_len <= i_job_len;
            r_cnt <= '0;
        end else if ((r_state == ST_STREAM) && w_op_fire) begin
            r_cnt <= r_cnt + LEN_W'(1);
        end
    end

    // Result capture: zero for empty jobs, accumulator output only while draining
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_fp4 <= FP4_ZERO;
        end else if ((r_state == ST_IDLE) && w_job_fire && (i_job_len == '0)) begin
            r_res_fp4 <= FP4_ZERO;
        end else if ((r_state == ST_DRAIN) && i_acc_fp4_valid) begin
            r_res_fp4 <= i_acc_fp4;
        end
    end

    fp4_seq_delay #(
        .DEPTH (LAT)
    ) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_tag (w_push),
        .o_tag (w_tag_out)
    );

    assign o_job_ready = r_job_ready;
    assign o_op_ready  = r_op_ready;
    assign o_acc_clear = r_acc_clear;
    assign o_acc_valid = w_tag_out.valid;
    assign o_acc_flush = w_tag_out.valid & w_tag_out.last;
    assign o_res_valid = r_res_valid;
    assign o_res_fp4   = r_res_fp4;
    assign o_busy      = r_busy;

endmodule

// File: doc/fp4_dot_sequencer.md
# fp4_dot_sequencer

Job-level controller for the FP4 MAC datapath. Accepts a dot-product job of N operand pairs, clears the FP4 accumulator, counts operand pairs into the multiplier, and aligns accumulate/flush strobes with the multiplier pipeline. It captures the packed FP4 result and returns it on a valid/ready result port. It sits between the operand streamer and the multiplier + accumulator pair; operand data bypasses this block, which handles control only.

## Interface
- LEN_W, 6: width of job length; max N = 2^LEN_W-1
- MUL_LAT, 1: cycles from operand-pair acceptance to product presented at accumulator input; legal 1..4
- i_clk  in  1  clock
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_job_valid  in  1  job request
- i_job_len  in  LEN_W  number of operand pairs N
- o_job_ready  out  1  block idle, job accepted on valid&ready
- i_op_valid  in  1  operand pair available at multiplier
- o_op_ready  out  1  operand pair consumed on valid&ready
- o_acc_clear  out  1  accumulator clear strobe
- o_acc_valid  out  1  accumulator consume-product strobe
- o_acc_flush  out  1  accumulator pack-output request
- i_acc_fp4_valid  in  1  accumulator packed result valid
- i_acc_fp4  in  4  accumulator packed result {s,e[1:0],m}
- o_res_valid  out  1  result valid
- o_res_fp4  out  4  result
- i_res_ready  in  1  result consumed on valid&ready
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, HOLD. Reset state is IDLE.
- IDLE: o_job_ready=1. On job fire, latch N and zero the issue counter.
  - N==0: go to HOLD with result 4'b0000. No clear, no strobes.
  - N>0: go to CLEAR.
- CLEAR: o_acc_clear=1 for exactly one cycle, o_op_ready=0, then STREAM. The accumulator gives clear priority over consume, so no o_acc_valid may coincide with o_acc_clear.
- STREAM: o_op_ready=1. Each fire increments the issue counter and pushes {valid=1, last=(count==N-1)} into the MUL_LAT-deep delay line. The fire of pair N goes to DRAIN.
- Delay line outputs:
  - o_acc_valid = stage-out valid.
  - o_acc_flush = stage-out valid & last.
  - The accumulator's flush result includes the product consumed in that cycle, so flush must coincide with the final o_acc_valid and never occur alone.
- DRAIN: o_op_ready=0. On i_acc_fp4_valid, register i_acc_fp4 into o_res_fp4 and go to HOLD.
- HOLD: o_res_valid=1 and o_res_fp4 stable until i_res_ready, then IDLE. o_job_ready stays 0 through the handoff cycle.
- i_acc_fp4_valid outside DRAIN is ignored. i_op_valid outside STREAM is not accepted.
- Counter width is LEN_W. Compare the counter against N-1, never N, so N = 2^LEN_W-1 does not wrap.

## Timing
- Reset values:
  - o_job_ready=1.
  - All other outputs 0, including o_res_fp4=4'b0000.
  - Delay line cleared.
- Reset mid-job returns to IDLE immediately. In-flight strobes are discarded. Stale accumulator contents are harmless because the next job clears.
- Cycle numbering, job fire at cycle 0, full-rate operands:
  - clear at 1
  - operand fires at 2..N+1
  - o_acc_valid at 2+MUL_LAT..N+1+MUL_LAT
  - flush at N+1+MUL_LAT
  - i_acc_fp4_valid at N+2+MUL_LAT
  - o_res_valid at N+3+MUL_LAT
- N==0: o_res_valid at cycle 1.
- Operand gaps delay all later strobes one-for-one. Strobes are registered outputs.
- Result backpressure holds the block in HOLD indefinitely with no new job accepted.

## Structure
- Shared package fp4_mac_pkg holds:
  - the state enum typedef
  - constant MUL_LAT_MAX=4
  - constant FP4_ZERO=4'b0000
- Sub-module fp4_seq_delay: MUL_LAT-stage {valid,last} shift register with async reset.

## Test plan
- Reset: assert i_rst mid-cycle -> all outputs 0 immediately, except o_job_ready=1 after reset.
- N=3, MUL_LAT=1, continuous operands, model returns 4'b0101 -> all of the following:
  - clear at 1, op_ready at 2-4
  - acc_valid at 3-5, flush only at 5
  - o_res_valid at 7 with 4'b0101
- N=0 -> o_res_valid at cycle 1 with 4'b0000, zero clear/valid/flush pulses.
- N=4, i_op_valid toggling 1,0,0,1,1,0,1 -> exactly 4 acc_valid pulses, flush only on the 4th, no strobe during CLEAR.
- N=2, i_res_ready low for 5 cycles with i_job_valid high -> o_res_fp4 stable, o_job_ready=0, and the job is accepted only the cycle after result handoff plus IDLE.
- Reset after 2 of 5 operands, then N=2 job -> fresh clear pulse, 2 acc_valid, flush on the 2nd, correct result.
- MUL_LAT=4, N=63 (LEN_W=6) -> 63 valid pulses, no counter wrap, o_res_valid at cycle 70.
